mem_access_unit: RTL and testbench

- Data-memory access stage that directly consumes the main decoder's memory controls (MemRead, MemWrite, MemNum, UnSigned) and the ALU-computed address.
- Performs byte, halfword and word loads and stores over a byte-wide, handshaked data-memory port, one byte per transfer, big-endian (MIPS).
- Sign- or zero-extends load data.
- Stalls the single-cycle core through stall_o until the access completes.

---
 rtl/mem_access_unit_if.sv | 38 +++
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Byte-wide data-memory port between the memory access stage (master) and the
// data memory (slave).
//
// Handshake: the master raises mem_req together with mem_we/mem_addr/mem_wdata
// and holds all of them stable until the slave returns mem_ack for exactly one
// cycle. The transfer completes on the rising edge where mem_req and mem_ack
// are both high. For reads, mem_rdata is only meaningful in that same cycle.
//
// Signals:
//   mem_req    master->slave  byte transfer request
//   mem_we     master->slave  1 = write byte, 0 = read byte
//   mem_addr   master->slave  byte address
//   mem_wdata  master->slave  write byte
//   mem_rdata  slave->master  read byte, valid with mem_ack
//   mem_ack    slave->master  transfer accepted/completed this cycle
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Data-memory access stage of a single-cycle MIPS-style core. Takes the
// decoder's MemRead/MemWrite/MemNum/UnSigned controls and the ALU address and
// performs byte, halfword or word loads/stores as a sequence of big-endian
// byte transfers on the mem port. The core is held through stall_o until the
// access finishes; done_o pulses with a status in err_o.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   MemRead_i           load request
//   MemWrite_i          store request (wins if both are set)
//   MemNum_i            size: 00 none, 01 byte, 10 half, 11 word
//   UnSigned_i          1 = zero-extend load, 0 = sign-extend
//   addr_i              byte address
//   wdata_i             store data
//   rdata_o             extended load result, held until the next good load
//   stall_o             core must hold its state this cycle
//   done_o              one-cycle completion pulse
//   err_o               with done_o: 00 ok, 01 misaligned, 10 ack timeout
//   mem                 byte-wide memory port (master side)
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [1:0]            MemNum_i,
  input  logic                  UnSigned_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [1:0]            err_o,
  mem_access_unit_if.master     mem
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE, ERR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            err_q, err_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [23:0]           acc_q, acc_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  req;
  logic                  misaligned;
  logic [1:0]            last_idx;
  logic [1:0]            shift;
  logic [31:0]           acc_nx;
  logic [31:0]           load_ext;
  logic [CW-1:0]         cnt_inc;

  assign req        = (MemRead_i | MemWrite_i) & (MemNum_i != 2'b00);
  assign misaligned = ((MemNum_i == 2'b10) & addr_i[0]) |
                      ((MemNum_i == 2'b11) & (addr_i[1:0] != 2'b00));

  // Index of the final byte: 0 for byte, 1 for half, 3 for word.
  always_comb begin
    case (size_q)
      2'b01:   last_idx = 2'd0;
      2'b10:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // Big-endian: index 0 carries the most significant byte of the N-byte field,
  // so the byte lane counts down from last_idx as the index counts up.
  assign shift   = last_idx - idx_q;
  assign acc_nx  = {acc_q, mem.mem_rdata};
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    case (size_q)
      2'b01:   load_ext = {{24{~uns_q & acc_nx[7]}},  acc_nx[7:0]};
      2'b10:   load_ext = {{16{~uns_q & acc_nx[15]}}, acc_nx[15:0]};
      default: load_ext = acc_nx;
    endcase
  end

  assign mem.mem_req   = (state_q == XFER);
  assign mem.mem_we    = (state_q == XFER) & we_q;
  assign mem.mem_addr  = base_q + ADDR_WIDTH'(idx_q);
  assign mem.mem_wdata = ((state_q == XFER) & we_q) ? wdata_q[{shift, 3'b000} +: 8] : 8'h00;
  assign rdata_o       = rdata_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    size_d  = size_q;
    idx_d   = idx_q;
    err_d   = err_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    err_o   = 2'b00;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall_o = 1'b1;
          if (misaligned) begin
            err_d   = 2'b01;
            state_d = ERR;
          end else begin
            base_d  = addr_i;
            size_d  = MemNum_i;
            we_d    = MemWrite_i;
            uns_d   = UnSigned_i;
            wdata_d = wdata_i;
            idx_d   = 2'd0;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = XFER;
          end
        end
      end
      XFER: begin
        stall_o = 1'b1;
        if (mem.mem_ack) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
          if (!we_q) acc_d = acc_nx[23:0];
          if (idx_q == last_idx) begin
            state_d = DONE;
            if (!we_q) rdata_d = load_ext;
          end
        end else if (cnt_inc == CW'(ACK_TIMEOUT)) begin
          err_d   = 2'b10;
          state_d = ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        // The request is still visible here, but the core advances this
        // cycle, so it must not be restarted.
        done_o  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      size_q  <= 2'b00;
      idx_q   <= 2'd0;
      err_q   <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit: byte-addressed memory slave with a
// programmable ack delay, a transaction-level model of each access, and one
// negedge compare process checking bus transfers, stall length, done/err and
// the load result.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic          MemRead_i = 1'b0;
  logic          MemWrite_i = 1'b0;
  logic [1:0]    MemNum_i = 2'b00;
  logic          UnSigned_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [31:0]   wdata_i = '0;
  logic [31:0]   rdata_o;
  logic          stall_o;
  logic          done_o;
  logic [1:0]    err_o;

  mem_access_unit_if #(.ADDR_WIDTH(AW)) mem_bus ();

  mem_access_unit #(.ADDR_WIDTH(AW), .ACK_TIMEOUT(TO)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .MemNum_i   (MemNum_i),
    .UnSigned_i (UnSigned_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .mem        (mem_bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [40:0] exp_q[$];          // {we, addr, byte}
  logic [40:0] head;
  logic [7:0]  mem [logic [31:0]];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          active = 1'b0;
  bit          seen_done = 1'b0;
  int          stall_cnt = 0;
  int          exp_stall = 0;
  logic [1:0]  exp_err = 2'b00;
  logic [31:0] exp_rdata = '0;
  logic [31:0] cur_rdata = '0;
  int          guard;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory slave ----------------
  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 8'h00;
  end

  always @(posedge clk_i) begin
    #1;
    if (mem_bus.mem_req && !rst_i) begin
      if (wait_cnt >= ack_delay) begin
        mem_bus.mem_ack = 1'b1;
        wait_cnt = 0;
        if (mem_bus.mem_we) begin
          mem[mem_bus.mem_addr] = mem_bus.mem_wdata;
          mem_bus.mem_rdata = 8'h00;
        end else begin
          mem_bus.mem_rdata = mem.exists(mem_bus.mem_addr) ? mem[mem_bus.mem_addr] : 8'h00;
        end
      end else begin
        mem_bus.mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_bus.mem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin
    if (!rst_i && active) begin
      if (stall_o) stall_cnt++;
      if (mem_bus.mem_req) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_req: got req at addr %h expected no request", mem_bus.mem_addr);
        end else begin
          head = exp_q[0];
          check("bus_addr", mem_bus.mem_addr, head[39:8]);
          check("bus_we", 32'(mem_bus.mem_we), 32'(head[40]));
          if (head[40]) check("bus_wdata", 32'(mem_bus.mem_wdata), 32'(head[7:0]));
          if (mem_bus.mem_ack) void'(exp_q.pop_front());
        end
      end
      if (done_o) begin
        check("done_err", 32'(err_o), 32'(exp_err));
        check("done_rdata", rdata_o, exp_rdata);
        check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        check("req_at_done", 32'(mem_bus.mem_req), 32'd0);
        if (exp_err == 2'b00) check("bytes_left", 32'(exp_q.size()), 32'd0);
        cur_rdata = exp_rdata;
        seen_done = 1'b1;
      end else begin
        check("err_not_done", 32'(err_o), 32'd0);
        check("rdata_hold", rdata_o, cur_rdata);
      end
    end
  end

  // ---------------- driver with access-level model ----------------
  task automatic do_access(input string name, input logic rd, input logic wr,
                           input logic [1:0] num, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int delay, input logic [31:0] lit_rdata);
    int          n;
    bit          mis;
    bit          tmo;
    logic [31:0] v;
    logic [31:0] sh;
    n   = (num == 2'd1) ? 1 : (num == 2'd2) ? 2 : 4;
    mis = (num == 2'd2 && a[0]) || (num == 2'd3 && a[1:0] != 2'b00);
    tmo = !mis && (delay >= TO);
    exp_q.delete();
    exp_rdata = cur_rdata;
    if (mis) begin
      exp_err   = 2'b01;
      exp_stall = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        sh = wd >> (8 * (n - 1 - i));
        if (!tmo || i == 0) exp_q.push_back({wr, a + 32'(i), wr ? sh[7:0] : 8'h00});
      end
      if (tmo) begin
        exp_err   = 2'b10;
        exp_stall = 1 + TO;
      end else begin
        exp_err   = 2'b00;
        exp_stall = 1 + n * (1 + delay);
        if (!wr) begin
          v = 0;
          for (int i = 0; i < n; i++) v = (v << 8) | 32'(mem[a + 32'(i)]);
          if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
          exp_rdata = v;
        end
      end
    end
    check({name, "_model"}, exp_rdata, lit_rdata);
    ack_delay = delay;
    @(posedge clk_i); #1;
    MemRead_i  = rd;
    MemWrite_i = wr;
    MemNum_i   = num;
    UnSigned_i = uns;
    addr_i     = a;
    wdata_i    = wd;
    stall_cnt  = 0;
    seen_done  = 1'b0;
    active     = 1'b1;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      @(posedge clk_i); #1;
    end
    if (!seen_done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_done_timeout: got no done_o expected done within 60 cycles", name);
    end
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    MemNum_i   = 2'b00;
    active     = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst_we", 32'(mem_bus.mem_we), 32'd0);
    check("rst_addr", mem_bus.mem_addr, 32'd0);
    check("rst_wdata", 32'(mem_bus.mem_wdata), 32'd0);
    rst_i = 1'b0;

    mem[32'h100] = 8'h80; mem[32'h101] = 8'h01; mem[32'h102] = 8'h02; mem[32'h103] = 8'h03;
    do_access("lw", 1, 0, 2'b11, 0, 32'h100, 32'h0, 0, 32'h80010203);

    mem[32'h102] = 8'hFF; mem[32'h103] = 8'h80;
    do_access("lh", 1, 0, 2'b10, 0, 32'h102, 32'h0, 0, 32'hFFFFFF80);
    do_access("lhu", 1, 0, 2'b10, 1, 32'h102, 32'h0, 0, 32'h0000FF80);

    mem[32'h3] = 8'h80;
    do_access("lb", 1, 0, 2'b01, 0, 32'h3, 32'h0, 0, 32'hFFFFFF80);
    mem[32'h3] = 8'h7F;
    do_access("lbu", 1, 0, 2'b01, 1, 32'h3, 32'h0, 0, 32'h0000007F);
    mem[32'h3] = 8'h80;
    do_access("lb_wait3", 1, 0, 2'b01, 0, 32'h3, 32'h0, 3, 32'hFFFFFF80);

    do_access("sw", 0, 1, 2'b11, 0, 32'h200, 32'hDEADBEEF, 0, 32'hFFFFFF80);
    check("sw_mem0", 32'(mem[32'h200]), 32'h000000DE);
    check("sw_mem1", 32'(mem[32'h201]), 32'h000000AD);
    check("sw_mem2", 32'(mem[32'h202]), 32'h000000BE);
    check("sw_mem3", 32'(mem[32'h203]), 32'h000000EF);
    do_access("sh", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'hFFFFFF80);
    check("sh_mem0", 32'(mem[32'h10]), 32'h000000BE);
    check("sh_mem1", 32'(mem[32'h11]), 32'h000000EF);
    // Read and write both set: treated as a store.
    do_access("sb_rw", 1, 1, 2'b01, 0, 32'h10, 32'hDEADBEEF, 0, 32'hFFFFFF80);
    check("sb_mem0", 32'(mem[32'h10]), 32'h000000EF);

    do_access("sw_mis", 0, 1, 2'b11, 0, 32'h101, 32'h12345678, 0, 32'hFFFFFF80);
    do_access("lh_mis", 1, 0, 2'b10, 0, 32'h7, 32'h0, 0, 32'hFFFFFF80);

    do_access("lw_tmo", 1, 0, 2'b11, 0, 32'h100, 32'h0, 100, 32'hFFFFFF80);

    // MemNum=00 is not a request even with MemRead set.
    @(posedge clk_i); #1;
    MemRead_i = 1'b1;
    MemNum_i  = 2'b00;
    addr_i    = 32'h100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check("noreq_stall", 32'(stall_o), 32'd0);
      check("noreq_req", 32'(mem_bus.mem_req), 32'd0);
      check("noreq_done", 32'(done_o), 32'd0);
    end
    @(posedge clk_i); #1;
    MemRead_i = 1'b0;

    // Reset in the middle of a word load, after two bytes have transferred.
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    ack_delay = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 32'h100 + 32'(i), 8'h00});
    exp_err   = 2'b00;
    exp_rdata = cur_rdata;
    exp_stall = 5;
    @(posedge clk_i); #1;
    MemRead_i = 1'b1;
    MemNum_i  = 2'b11;
    UnSigned_i = 1'b0;
    addr_i    = 32'h100;
    stall_cnt = 0;
    seen_done = 1'b0;
    active    = 1'b1;
    guard     = 0;
    while (exp_q.size() > 2 && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    check("rst_mid_bytes_done", 32'(exp_q.size()), 32'd2);
    active    = 1'b0;
    rst_i     = 1'b1;
    MemRead_i = 1'b0;
    MemNum_i  = 2'b00;
    #1;
    check("rstmid_req", 32'(mem_bus.mem_req), 32'd0);
    check("rstmid_rdata", rdata_o, 32'd0);
    check("rstmid_stall", 32'(stall_o), 32'd0);
    check("rstmid_done", 32'(done_o), 32'd0);
    check("rstmid_err", 32'(err_o), 32'd0);
    check("rstmid_addr", mem_bus.mem_addr, 32'd0);
    check("rstmid_we", 32'(mem_bus.mem_we), 32'd0);
    exp_q.delete();
    cur_rdata = 32'd0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Unit resumes normal operation from IDLE.
    mem[32'h3] = 8'h80;
    do_access("lbu_after_rst", 1, 0, 2'b01, 1, 32'h3, 32'h0, 0, 32'h00000080);

    repeat (2) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
